// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared types and constants for the dispatch stage
package dispatch_pkg;

  localparam int DISP_PC_W = 9;

  localparam logic [1:0] FU_ALU = 2'b00;
  localparam logic [1:0] FU_BR  = 2'b01;
  localparam logic [1:0] FU_LSU = 2'b10;
  localparam logic [1:0] FU_ILL = 2'b11;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  typedef struct packed {
    logic [DISP_PC_W-1:0] pc;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [31:0]          imm;
    logic [3:0]           aluop;
    logic [1:0]           futype;
    logic                 alusrc;
    logic                 branch;
    logic                 memread;
    logic                 memwrite;
    logic                 regwrite;
  } dispatch_bundle_t;

endpackage

// File: rtl/dispatch_fifo.sv
// rtl/dispatch_fifo.sv - 2-entry in-order bundle queue; entry 0 is always the head
module dispatch_fifo
  import dispatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  logic             deq,
  input  dispatch_bundle_t din,
  output dispatch_bundle_t head,
  output logic [1:0]       count
);

  q_state_e         state_q, state_d;
  dispatch_bundle_t e0_q, e0_d;
  dispatch_bundle_t e1_q, e1_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Q_EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  // Enqueue while FULL is never issued by the controller, so it is ignored here.
  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (flush) begin
      state_d = Q_EMPTY;
    end else begin
      case (state_q)
        Q_EMPTY: begin
          if (enq) begin
            e0_d    = din;
            state_d = Q_ONE;
          end
        end
        Q_ONE: begin
          if (enq && deq) begin
            e0_d = din;
          end else if (enq) begin
            e1_d    = din;
            state_d = Q_FULL;
          end else if (deq) begin
            state_d = Q_EMPTY;
          end
        end
        Q_FULL: begin
          if (deq) begin
            e0_d    = e1_q;
            state_d = Q_ONE;
          end
        end
        default: state_d = Q_EMPTY;
      endcase
    end
  end

  assign head  = e0_q;
  assign count = state_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - steers the queued head bundle to the ALU/branch/LSU stations
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [4:0]       i_rd,
  input  logic [31:0]      i_imm,
  input  logic [3:0]       i_aluop,
  input  logic [1:0]       i_futype,
  input  logic             i_alusrc,
  input  logic             i_branch,
  input  logic             i_memread,
  input  logic             i_memwrite,
  input  logic             i_regwrite,
  input  logic             rob_ready,
  input  logic             prf_ready,
  input  logic             alu_rs_ready,
  input  logic             br_rs_ready,
  input  logic             lsu_rs_ready,
  output logic             o_valid_alu,
  output logic             o_valid_br,
  output logic             o_valid_lsu,
  output logic [PC_W-1:0]  o_pc,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [4:0]       o_rd,
  output logic [31:0]      o_imm,
  output logic [3:0]       o_aluop,
  output logic             o_alusrc,
  output logic             o_branch,
  output logic             o_memread,
  output logic             o_memwrite,
  output logic             o_regwrite,
  output logic             rob_alloc,
  output logic             prf_alloc,
  output logic             illegal,
  output logic [CNT_W-1:0] dispatch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  dispatch_bundle_t din, head, hd;
  logic [1:0]       count;
  logic             head_valid, needs_prf, res_ok, fire, enq, deq;

  always_comb begin
    din          = '0;
    din.pc       = DISP_PC_W'(i_pc);
    din.rs1      = i_rs1;
    din.rs2      = i_rs2;
    din.rd       = i_rd;
    din.imm      = i_imm;
    din.aluop    = i_aluop;
    din.futype   = i_futype;
    din.alusrc   = i_alusrc;
    din.branch   = i_branch;
    din.memread  = i_memread;
    din.memwrite = i_memwrite;
    din.regwrite = i_regwrite;
  end

  dispatch_fifo u_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (flush),
    .enq   (enq),
    .deq   (deq),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign head_valid = (count != 2'd0);
  assign o_ready    = (count != 2'd2);
  assign enq        = i_valid && o_ready && !flush;
  assign hd         = head_valid ? head : '0;

  assign needs_prf = hd.regwrite && (hd.rd != 5'd0);
  assign res_ok    = rob_ready && (!needs_prf || prf_ready);

  // Valids are offered independently of RS readiness; the handshake decides fire.
  always_comb begin
    o_valid_alu = 1'b0;
    o_valid_br  = 1'b0;
    o_valid_lsu = 1'b0;
    illegal     = 1'b0;
    if (head_valid && !flush) begin
      o_valid_alu = (hd.futype == FU_ALU) && res_ok;
      o_valid_br  = (hd.futype == FU_BR)  && res_ok;
      o_valid_lsu = (hd.futype == FU_LSU) && res_ok;
      illegal     = (hd.futype == FU_ILL);
    end
  end

  assign fire      = (o_valid_alu && alu_rs_ready) || (o_valid_br && br_rs_ready) ||
                     (o_valid_lsu && lsu_rs_ready);
  assign deq       = fire || illegal;
  assign rob_alloc = fire;
  assign prf_alloc = fire && needs_prf;

  assign o_pc       = PC_W'(hd.pc);
  assign o_rs1      = hd.rs1;
  assign o_rs2      = hd.rs2;
  assign o_rd       = hd.rd;
  assign o_imm      = hd.imm;
  assign o_aluop    = hd.aluop;
  assign o_alusrc   = hd.alusrc;
  assign o_branch   = hd.branch;
  assign o_memread  = hd.memread;
  assign o_memwrite = hd.memwrite;
  assign o_regwrite = hd.regwrite;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dispatch_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (fire)
        dispatch_cnt <= dispatch_cnt + CNT_W'(1);
      if (head_valid && !fire && !illegal && !flush)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb/tb_dispatch_ctrl.sv - self-checking bench for dispatch_ctrl
module tb_dispatch_ctrl;
  import dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, i_valid, o_ready;
  logic [8:0]  i_pc, o_pc;
  logic [4:0]  i_rs1, i_rs2, i_rd, o_rs1, o_rs2, o_rd;
  logic [31:0] i_imm, o_imm;
  logic [3:0]  i_aluop, o_aluop;
  logic [1:0]  i_futype;
  logic        i_alusrc, i_branch, i_memread, i_memwrite, i_regwrite;
  logic        rob_ready, prf_ready, alu_rs_ready, br_rs_ready, lsu_rs_ready;
  logic        o_valid_alu, o_valid_br, o_valid_lsu;
  logic        o_alusrc, o_branch, o_memread, o_memwrite, o_regwrite;
  logic        rob_alloc, prf_alloc, illegal;
  logic [15:0] dispatch_cnt, stall_cnt;
  logic [6:0]  ctl;

  always #5 clk = ~clk;

  dispatch_ctrl #(.PC_W(9), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_imm(i_imm),
    .i_aluop(i_aluop), .i_futype(i_futype), .i_alusrc(i_alusrc), .i_branch(i_branch),
    .i_memread(i_memread), .i_memwrite(i_memwrite), .i_regwrite(i_regwrite),
    .rob_ready(rob_ready), .prf_ready(prf_ready), .alu_rs_ready(alu_rs_ready),
    .br_rs_ready(br_rs_ready), .lsu_rs_ready(lsu_rs_ready),
    .o_valid_alu(o_valid_alu), .o_valid_br(o_valid_br), .o_valid_lsu(o_valid_lsu),
    .o_pc(o_pc), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm),
    .o_aluop(o_aluop), .o_alusrc(o_alusrc), .o_branch(o_branch), .o_memread(o_memread),
    .o_memwrite(o_memwrite), .o_regwrite(o_regwrite), .rob_alloc(rob_alloc),
    .prf_alloc(prf_alloc), .illegal(illegal), .dispatch_cnt(dispatch_cnt),
    .stall_cnt(stall_cnt)
  );

  assign ctl = {o_valid_alu, o_valid_br, o_valid_lsu, rob_alloc, prf_alloc, illegal, o_ready};

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] pc_tag = 9'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // rdy = {rob, prf, alu_rs, br_rs, lsu_rs}
  task automatic drive(input logic iv, input logic [1:0] fut, input logic [4:0] rd,
                       input logic rw, input logic [4:0] rdy, input logic fl);
    i_valid      = iv;
    i_futype     = fut;
    i_rd         = rd;
    i_regwrite   = rw;
    i_pc         = pc_tag;
    pc_tag       = pc_tag + 9'd1;
    i_rs1        = 5'($urandom);
    i_rs2        = 5'($urandom);
    i_imm        = $urandom;
    i_aluop      = 4'($urandom);
    i_alusrc     = 1'($urandom);
    i_branch     = (fut == FU_BR);
    i_memread    = (fut == FU_LSU);
    i_memwrite   = 1'b0;
    {rob_ready, prf_ready, alu_rs_ready, br_rs_ready, lsu_rs_ready} = rdy;
    flush        = fl;
  endtask

  typedef struct {
    logic       iv;
    logic [1:0] fut;
    logic [4:0] rd;
    logic       rw;
    logic [4:0] rdy;
    logic       fl;
    logic [6:0] ectl;  // {valid alu,br,lsu, rob_alloc, prf_alloc, illegal, o_ready}
    logic [4:0] erd;
    logic [15:0] edc;
    logic [15:0] esc;
  } vec_t;

  vec_t vt[17];

  typedef struct {
    logic [8:0]  pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [1:0]  fut;
    logic        rw;
  } mb_t;

  mb_t        mq[$];
  logic [15:0] m_dc, m_sc;

  initial begin
    vt[0]  = '{1'b1, FU_ALU, 5'd5, 1'b1, 5'b11111, 1'b0, 7'b0000001, 5'd0, 16'd0, 16'd0};
    vt[1]  = '{1'b0, FU_ALU, 5'd0, 1'b0, 5'b11111, 1'b0, 7'b1001101, 5'd5, 16'd0, 16'd0};
    vt[2]  = '{1'b1, FU_BR,  5'd3, 1'b0, 5'b10111, 1'b0, 7'b0000001, 5'd0, 16'd1, 16'd0};
    vt[3]  = '{1'b0, FU_ALU, 5'd0, 1'b0, 5'b10111, 1'b0, 7'b0101001, 5'd3, 16'd1, 16'd0};
    vt[4]  = '{1'b1, FU_LSU, 5'd7, 1'b1, 5'b11110, 1'b0, 7'b0000001, 5'd0, 16'd2, 16'd0};
    vt[5]  = '{1'b1, FU_ALU, 5'd1, 1'b1, 5'b11110, 1'b0, 7'b0010001, 5'd7, 16'd2, 16'd0};
    vt[6]  = '{1'b1, FU_ALU, 5'd2, 1'b1, 5'b11110, 1'b0, 7'b0010000, 5'd7, 16'd2, 16'd1};
    vt[7]  = '{1'b1, FU_ALU, 5'd2, 1'b1, 5'b11110, 1'b0, 7'b0010000, 5'd7, 16'd2, 16'd2};
    vt[8]  = '{1'b1, FU_ALU, 5'd2, 1'b1, 5'b11111, 1'b0, 7'b0011100, 5'd7, 16'd2, 16'd3};
    vt[9]  = '{1'b1, FU_ALU, 5'd2, 1'b1, 5'b11111, 1'b0, 7'b1001101, 5'd1, 16'd3, 16'd3};
    vt[10] = '{1'b1, FU_ILL, 5'd4, 1'b1, 5'b11111, 1'b0, 7'b1001101, 5'd2, 16'd4, 16'd3};
    vt[11] = '{1'b1, FU_ALU, 5'd0, 1'b1, 5'b10111, 1'b0, 7'b0000011, 5'd4, 16'd5, 16'd3};
    vt[12] = '{1'b0, FU_ALU, 5'd0, 1'b0, 5'b10111, 1'b0, 7'b1001001, 5'd0, 16'd5, 16'd3};
    vt[13] = '{1'b1, FU_ALU, 5'd9, 1'b1, 5'b11011, 1'b0, 7'b0000001, 5'd0, 16'd6, 16'd3};
    vt[14] = '{1'b1, FU_BR,  5'd3, 1'b0, 5'b11011, 1'b0, 7'b1000001, 5'd9, 16'd6, 16'd3};
    vt[15] = '{1'b1, FU_LSU, 5'd7, 1'b1, 5'b11011, 1'b1, 7'b0000000, 5'd0, 16'd6, 16'd4};
    vt[16] = '{1'b0, FU_ALU, 5'd0, 1'b0, 5'b11111, 1'b0, 7'b0000001, 5'd0, 16'd6, 16'd4};

    reset = 1'b1;
    drive(1'b0, FU_ALU, 5'd0, 1'b0, 5'b00000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_ctl", 32'(ctl), 32'h01);
    chk("reset_dispatch_cnt", 32'(dispatch_cnt), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vt[i].iv, vt[i].fut, vt[i].rd, vt[i].rw, vt[i].rdy, vt[i].fl);
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vt[i].ectl));
      chk($sformatf("vec%0d_dispatch_cnt", i), 32'(dispatch_cnt), 32'(vt[i].edc));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(vt[i].esc));
      if ((vt[i].ectl[6:4] != 3'b000) || vt[i].ectl[1])
        chk($sformatf("vec%0d_rd", i), 32'(o_rd), 32'(vt[i].erd));
      @(posedge clk);
    end

    // Long stall on an ALU head to push stall_cnt through its wrap point.
    @(negedge clk);
    drive(1'b1, FU_ALU, 5'd5, 1'b1, 5'b11011, 1'b0);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (65531) @(posedge clk);
    @(negedge clk);
    #1;
    chk("stall_cnt_max", 32'(stall_cnt), 32'hFFFF);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("stall_cnt_wrap", 32'(stall_cnt), 32'h0000);
    chk("held_valid_alu", 32'(o_valid_alu), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_ctl", 32'(ctl), 32'h01);
    chk("async_reset_dispatch_cnt", 32'(dispatch_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, FU_ALU, 5'd0, 1'b0, 5'b11111, 1'b0);
    reset = 1'b0;
    @(posedge clk);

    mq.delete();
    m_dc = '0;
    m_sc = '0;
    for (int c = 0; c < 3000; c++) begin
      logic       hv, needs, ok, fire, ill, rdy_e;
      logic [2:0] ev;
      mb_t        h, nb;
      @(negedge clk);
      drive($urandom_range(0, 9) < 7, 2'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            1'($urandom), {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0},
            $urandom_range(0, 19) == 0);
      #1;
      hv    = (mq.size() > 0);
      h     = hv ? mq[0] : '{default: '0};
      needs = h.rw && (h.rd != 0);
      ok    = rob_ready && (!needs || prf_ready);
      ev    = 3'b000;
      if (hv && ok && !flush && h.fut != FU_ILL) ev[2 - h.fut] = 1'b1;
      fire  = (ev[2] && alu_rs_ready) || (ev[1] && br_rs_ready) || (ev[0] && lsu_rs_ready);
      ill   = hv && !flush && (h.fut == FU_ILL);
      rdy_e = (mq.size() < 2);
      chk($sformatf("rnd%0d_ctl", c), 32'(ctl), 32'({ev, fire, fire && needs, ill, rdy_e}));
      chk($sformatf("rnd%0d_dispatch_cnt", c), 32'(dispatch_cnt), 32'(m_dc));
      chk($sformatf("rnd%0d_stall_cnt", c), 32'(stall_cnt), 32'(m_sc));
      if (hv) begin
        chk($sformatf("rnd%0d_pc", c), 32'(o_pc), 32'(h.pc));
        chk($sformatf("rnd%0d_rd", c), 32'(o_rd), 32'(h.rd));
        chk($sformatf("rnd%0d_imm", c), o_imm, h.imm);
      end
      nb = '{i_pc, i_rd, i_imm, i_futype, i_regwrite};
      if (fire) m_dc = m_dc + 16'd1;
      if (hv && !fire && !ill && !flush) m_sc = m_sc + 16'd1;
      if (flush) begin
        mq.delete();
      end else begin
        if (fire || ill) void'(mq.pop_front());
        if (i_valid && rdy_e) mq.push_back(nb);
      end
      @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Sits between the decoder and the three reservation stations (ALU, branch, LSU).
- Buffers decoded bundles in a 2-entry in-order queue and steers the head bundle to the RS selected by FUtype.
- Dispatches only when the target RS, the ROB and (when needed) the physical-register free list can all accept.
- Drives the decoder's i_ready and keeps dispatch/stall performance counters.

Parameters:
- PC_W, 9, width of PC field carried with each bundle.
- CNT_W, 16, width of the dispatch and stall performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  mispredict flush; empties the queue
- i_valid  in  1  decoded bundle valid (decoder o_valid)
- o_ready  out  1  queue can accept (to decoder i_ready)
- i_pc  in  PC_W  bundle PC
- i_rs1, i_rs2, i_rd  in  5 each  register indices
- i_imm  in  32  immediate
- i_aluop  in  4  ALUOp
- i_futype  in  2  00 ALU, 01 branch, 10 LSU, 11 illegal
- i_alusrc, i_branch, i_memread, i_memwrite, i_regwrite  in  1 each  control bits
- rob_ready  in  1  ROB has a free entry
- prf_ready  in  1  free list has a free physical register
- alu_rs_ready, br_rs_ready, lsu_rs_ready  in  1 each  RS can accept
- o_valid_alu, o_valid_br, o_valid_lsu  out  1 each  per-RS dispatch valid
- o_pc, o_rs1, o_rs2, o_rd, o_imm, o_aluop, o_alusrc, o_branch, o_memread, o_memwrite, o_regwrite  out  as inputs  head bundle fields, shared by all RS
- rob_alloc  out  1  ROB allocate pulse
- prf_alloc  out  1  free-list pop pulse
- illegal  out  1  pulse when a FUtype=11 head is dropped
- dispatch_cnt, stall_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (async, active-high): queue empty, counters 0, all o_valid_* / rob_alloc / prf_alloc / illegal = 0, o_ready = 1. Bundle outputs are don't-care but are driven 0.
- Queue occupancy states EMPTY, ONE, FULL (count 0/1/2).
- o_ready = (count != 2), a function of registered state only. When FULL, no enqueue occurs even if a dequeue happens that cycle.
- enq = i_valid && o_ready && !flush.
- Latency: bundle enqueued at edge N is the head from cycle N+1. Earliest dispatch is cycle N+1, so best case is 1 bundle per cycle.
- needs_prf = head.regwrite && head.rd != 0.
- res_ok = rob_ready && (!needs_prf || prf_ready).
- o_valid_X = head_valid && head.futype == X && res_ok && !flush. It must not depend on X_rs_ready.
- fire = o_valid_X && X_rs_ready for the selected X.
- rob_alloc = fire. prf_alloc = fire && needs_prf.
- head.futype == 11 and !flush:
  - head dequeued that cycle with no o_valid_*, no rob_alloc and no prf_alloc;
  - illegal = 1 for that cycle;
  - counts neither as dispatch nor as stall.
- deq = fire || illegal.
- Simultaneous enq and deq in ONE: count stays 1 and the new bundle becomes head. In EMPTY, enq only.
- flush: all outputs valid-low that cycle; queue empty after the edge; no enqueue that cycle; counters unchanged. Flush has priority over every other event.
- dispatch_cnt += 1 on each fire; wraps modulo 2^CNT_W.
- stall_cnt += 1 each cycle with head_valid && !fire && !illegal && !flush; wraps.
- Order is strictly in-order; the second entry never dispatches before the head.
- Reset asserted mid-operation: queue discarded asynchronously and outputs drop the same cycle.

Decomposition:
- dispatch_pkg contains:
  - FU_ALU = 2'b00, FU_BR = 2'b01, FU_LSU = 2'b10, FU_ILL = 2'b11;
  - typedef struct packed dispatch_bundle_t with all bundle fields.
- Sub-module dispatch_fifo: 2-entry queue of dispatch_bundle_t with enq/deq/flush/count.
- dispatch_ctrl holds the steering, resource checks and counters.

Test Plan:
- Reset, then ALU bundle (futype 00, rd=5, regwrite=1) with all readies 1 → o_valid_alu=1, rob_alloc=1, prf_alloc=1 one cycle after enq; dispatch_cnt=1.
- Branch bundle (futype 01, regwrite=0) with prf_ready=0 → still dispatches: o_valid_br=1, prf_alloc=0.
- LSU load with lsu_rs_ready=0 for 3 cycles, then decoder drives 2 more bundles → o_valid_lsu=1 held; o_ready=0 after 2 enqueued; stall_cnt=3; on release, both entries dispatch in order on consecutive cycles.
- Head futype 11 → illegal=1 for one cycle, no alloc pulses; next bundle dispatches the following cycle.
- Queue FULL plus flush with i_valid=1 → no o_valid_*, count=0 next cycle, o_ready=1, new bundle not captured.
- ALU bundle with rd=0, regwrite=1, prf_ready=0 → dispatches with prf_alloc=0; stall_cnt wraps 0xFFFF→0x0000 on a forced long stall.
